// File: rtl/data_ram_slave.sv
// data_ram_slave: single-port 64-bit data RAM responder on the shared memory bus.
// Simplified AHB-Lite protocol: 1-bit HTRANS, pipelined address and data phases,
// WAIT_STATES HREADY-low cycles per data phase, and an optional two-cycle error response.
//
// Ports:
//   CLK, RESET      rising-edge clock, asynchronous active-low reset
//   HSEL, HTRANS    slave select and active-transfer flag
//   HADDR           byte address (address phase)
//   HWRITE, HSIZE   direction and size (00 byte .. 11 dword) (address phase)
//   HWDATA          lane-aligned little-endian write data (data phase)
//   HRDATA          full 64-bit word containing the read address
//   HREADY, HRESP   data phase completion and error response
//
// Build option: define DATA_RAM_ERR_EN to return an error for misaligned or out-of-range
// accesses. Without it, HRESP is always 0, the word index wraps, and misaligned addresses
// are force-aligned.
module data_ram_slave #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [63:0] BASE_ADDR   = 64'h0000_0000_8000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        HSEL,
  input  logic        HTRANS,
  input  logic [63:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HSIZE,
  input  logic [63:0] HWDATA,
  output logic [63:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] WAIT_LAST =
    CNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  // Address-phase information carried into the data phase
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [7:0]       mask;
    logic             write;
  } aphase_t;

  // Clear the low log2(size) offset bits
  function automatic logic [2:0] align_off(input logic [2:0] off, input logic [1:0] size);
    logic [2:0] res;
    case (size)
      2'd0:    res = off;
      2'd1:    res = {off[2:1], 1'b0};
      2'd2:    res = {off[2], 2'b00};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  // Byte-lane enables for a size-aligned offset
  function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [7:0]        mask);
    logic [DATA_W-1:0] res;
    for (int b = 0; b < 8; b++) begin
      res[8*b +: 8] = mask[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  aphase_t           ap_q;

  logic [ADDR_W-1:0] rel_c;
  logic [2:0]        off_c;
  logic              accept_c;
  logic              err_c;
  aphase_t           new_ap_c;
  logic              wr_commit_c;
  logic [IDX_W-1:0]  rd_idx_c;
  logic [DATA_W-1:0] rd_fwd_c;

  // Address-phase decode
  always_comb begin
    rel_c          = HADDR - BASE_ADDR;
    off_c          = align_off(rel_c[2:0], HSIZE);
    accept_c       = HSEL & HTRANS & HREADY;
    new_ap_c.idx   = rel_c[IDX_W+2:3];
    new_ap_c.mask  = lane_mask(off_c, HSIZE);
    new_ap_c.write = HWRITE;
`ifdef DATA_RAM_ERR_EN
    err_c = (off_c != rel_c[2:0]) | (rel_c[ADDR_W-1:IDX_W+3] != '0);
`else
    err_c = 1'b0;
`endif
  end

`ifndef DATA_RAM_ERR_EN
  // Upper offset bits only matter for the range check
  logic unused_rel_c;
  assign unused_rel_c = ^rel_c[ADDR_W-1:IDX_W+3];
`endif

  // Read port with forwarding: with no wait states a read can be accepted on the
  // same edge that a write to the same word commits, so merge the write lanes in.
  always_comb begin
    wr_commit_c = (state == S_DATA) && ap_q.write;
    rd_idx_c    = (state == S_WAIT) ? ap_q.idx : new_ap_c.idx;
    rd_fwd_c    = mem[rd_idx_c];
    if (wr_commit_c && (ap_q.idx == rd_idx_c)) begin
      rd_fwd_c = merge_lanes(rd_fwd_c, HWDATA, ap_q.mask);
    end
  end

  // RAM array, not reset; the write commits on the edge ending the data phase
  always_ff @(posedge CLK) begin
    if (wr_commit_c) begin
      mem[ap_q.idx] <= merge_lanes(mem[ap_q.idx], HWDATA, ap_q.mask);
    end
  end

  // Transfer FSM with registered bus outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ap_q   <= '0;
      HREADY <= 1'b1;
      HRESP  <= 1'b0;
      HRDATA <= '0;
    end else if (accept_c) begin
      // Accept is only possible in IDLE, DATA or ERR2 (HREADY high)
      cnt <= '0;
      if (err_c) begin
        state  <= S_ERR1;
        HREADY <= 1'b0;
        HRESP  <= 1'b1;
      end else if (WAIT_STATES != 0) begin
        ap_q   <= new_ap_c;
        state  <= S_WAIT;
        HREADY <= 1'b0;
        HRESP  <= 1'b0;
      end else begin
        ap_q   <= new_ap_c;
        state  <= S_DATA;
        HREADY <= 1'b1;
        HRESP  <= 1'b0;
        if (!HWRITE) begin
          HRDATA <= rd_fwd_c;
        end
      end
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state  <= S_DATA;
            HREADY <= 1'b1;
            if (!ap_q.write) begin
              HRDATA <= rd_fwd_c;
            end
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_ERR1: begin
          state  <= S_ERR2;
          HREADY <= 1'b1;
          HRESP  <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          HREADY <= 1'b1;
          HRESP  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_slave.sv
// Scoreboard bench for data_ram_slave: one instance with one wait state, one with none.
module tb_data_ram_slave;

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel, htrans, hwrite, use0;
  logic [63:0] haddr, hwdata;
  logic [1:0]  hsize;
  logic [63:0] hrdata1, hrdata0;
  logic        hready1, hready0, hresp1, hresp0;
  logic        m_ready, m_resp;
  logic [63:0] m_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_ram_slave #(.DEPTH_WORDS(512), .WAIT_STATES(1), .BASE_ADDR(BASE)) u_ws1 (
    .CLK(clk), .RESET(rst_n), .HSEL(hsel & ~use0), .HTRANS(htrans), .HADDR(haddr),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1)
  );

  data_ram_slave #(.DEPTH_WORDS(512), .WAIT_STATES(0), .BASE_ADDR(BASE)) u_ws0 (
    .CLK(clk), .RESET(rst_n), .HSEL(hsel & use0), .HTRANS(htrans), .HADDR(haddr),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata),
    .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0)
  );

  assign m_ready = use0 ? hready0 : hready1;
  assign m_resp  = use0 ? hresp0  : hresp1;
  assign m_rdata = use0 ? hrdata0 : hrdata1;

  typedef struct {
    string       nm;
    bit          chk_data;
    bit          neq;
    logic [63:0] data;
    logic        resp;
    int          lowcyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   pending;
  int   lowcnt;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_ne(input string nm, input logic [63:0] act, input logic [63:0] avoid);
    total++;
    if (act === avoid) begin
      bad++;
      $display("FAIL %s actual=%h required=not %h", nm, act, avoid);
    end
  endtask

  // Monitor: a transfer completes at the first sample with HREADY high after its accept
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending = 1'b0;
      lowcnt  = 0;
    end else begin
      if (pending) begin
        if (m_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_completion actual=1 required=0");
          end else begin
            mon_e = exp_q.pop_front();
            chk({mon_e.nm, "_resp"}, 64'(m_resp), 64'(mon_e.resp));
            chk({mon_e.nm, "_waits"}, 64'(lowcnt), 64'(mon_e.lowcyc));
            if (mon_e.chk_data) begin
              if (mon_e.neq) chk_ne({mon_e.nm, "_data"}, m_rdata, mon_e.data);
              else           chk({mon_e.nm, "_data"}, m_rdata, mon_e.data);
            end
          end
          pending = 1'b0;
        end else begin
          lowcnt++;
        end
      end
      if (hsel && htrans && m_ready) begin
        pending = 1'b1;
        lowcnt  = 0;
      end
    end
  end

  // Present an address phase, return just after the accepting edge with the data phase driven
  task automatic issue(input bit w, input logic [63:0] a, input logic [1:0] sz,
                       input logic [63:0] wd);
    int n = 0;
    hsel = 1'b1; htrans = 1'b1; haddr = a; hwrite = w; hsize = sz;
    @(negedge clk);
    while (!m_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!m_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 1'b0; hwrite = 1'b0;
    if (w) hwdata = wd;
  endtask

  task automatic push(input string nm, input bit cd, input bit ne, input logic [63:0] d,
                      input logic r, input int lc);
    exp_t e;
    e.nm = nm; e.chk_data = cd; e.neq = ne; e.data = d; e.resp = r; e.lowcyc = lc;
    exp_q.push_back(e);
  endtask

  task automatic wr(input string nm, input logic [63:0] a, input logic [1:0] sz,
                    input logic [63:0] wd);
    push(nm, 1'b0, 1'b0, '0, 1'b0, use0 ? 0 : 1);
    issue(1'b1, a, sz, wd);
  endtask

  task automatic rd(input string nm, input logic [63:0] a, input logic [1:0] sz,
                    input logic [63:0] d);
    push(nm, 1'b1, 1'b0, d, 1'b0, use0 ? 0 : 1);
    issue(1'b0, a, sz, '0);
  endtask

  task automatic rd_ne(input string nm, input logic [63:0] a, input logic [63:0] d);
    push(nm, 1'b1, 1'b1, d, 1'b0, use0 ? 0 : 1);
    issue(1'b0, a, 2'd3, '0);
  endtask

  task automatic xfer_err(input string nm, input bit w, input logic [63:0] a,
                          input logic [1:0] sz, input logic [63:0] wd);
    push(nm, 1'b0, 1'b0, '0, 1'b1, 1);
    issue(w, a, sz, wd);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || pending) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0 || pending) begin
      total++;
      bad++;
      $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hsel = 0; htrans = 0; haddr = '0; hwrite = 0; hsize = '0; hwdata = '0; use0 = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hready", 64'(hready1), 64'd1);
    chk("rst_hresp", 64'(hresp1), 64'd0);
    chk("rst_hrdata", hrdata1, 64'd0);
    chk("rst_hready_ws0", 64'(hready0), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One wait state
    wr("dw_wr", BASE + 64'h8, 2'd3, 64'hDEADBEEF_CAFEF00D);
    rd("dw_rd", BASE + 64'h8, 2'd3, 64'hDEADBEEF_CAFEF00D);
    wr("byte_wr", BASE + 64'h9, 2'd0, 64'h0000_0000_0000_AA00);
    rd("byte_rd", BASE + 64'h8, 2'd3, 64'hDEADBEEF_CAFEAA0D);
    wr("word_wr", BASE + 64'hC, 2'd2, 64'h12345678_00000000);
    drain();
    chk("hold_after_wr", hrdata1, 64'hDEADBEEF_CAFEAA0D);
    rd("word_rd", BASE + 64'h8, 2'd3, 64'h12345678_CAFEAA0D);
    wr("w0_wr", BASE, 2'd3, 64'h0F0E0D0C_0B0A0908);
    drain();

    // Reset during the wait state of a write aborts it
    issue(1'b1, BASE + 64'h10, 2'd3, 64'h11223344_55667788);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_hready", 64'(hready1), 64'd1);
    chk("midrst_hresp", 64'(hresp1), 64'd0);
    chk("midrst_hrdata", hrdata1, 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    rd_ne("aborted_wr_rd", BASE + 64'h10, 64'h11223344_55667788);
    rd("retain_rd", BASE + 64'h8, 2'd3, 64'h12345678_CAFEAA0D);
    drain();

`ifdef DATA_RAM_ERR_EN
    xfer_err("mis_rd", 1'b0, BASE + 64'h2, 2'd2, '0);
    drain();
    chk("err_idle_hresp", 64'(hresp1), 64'd0);
    chk("err_idle_hready", 64'(hready1), 64'd1);
    chk("err_hrdata_kept", hrdata1, 64'h12345678_CAFEAA0D);
    xfer_err("oor_rd", 1'b0, BASE + 64'h1000, 2'd3, '0);
    rd("err2_accept_rd", BASE, 2'd3, 64'h0F0E0D0C_0B0A0908);
    xfer_err("mis_wr", 1'b1, BASE + 64'h9, 2'd3, 64'h01234567_89ABCDEF);
    rd("mis_wr_rd", BASE + 64'h8, 2'd3, 64'h12345678_CAFEAA0D);
    drain();
`else
    rd("mis_rd", BASE + 64'h2, 2'd2, 64'h0F0E0D0C_0B0A0908);
    drain();
    chk("idle_hresp", 64'(hresp1), 64'd0);
    rd("wrap_rd", BASE + 64'h1000, 2'd3, 64'h0F0E0D0C_0B0A0908);
    wr("mis_wr", BASE + 64'h9, 2'd3, 64'h01234567_89ABCDEF);
    rd("mis_wr_rd", BASE + 64'h8, 2'd3, 64'h01234567_89ABCDEF);
    drain();
`endif

    // No wait states: back-to-back transfers and write-to-read forwarding
    use0 = 1'b1;
    wr("b2b_wr", BASE, 2'd3, 64'h1);
    rd("b2b_rd", BASE, 2'd3, 64'h1);
    wr("fill_wr", BASE + 64'h8, 2'd3, 64'hAAAAAAAA_AAAAAAAA);
    wr("half_wr", BASE + 64'hA, 2'd1, 64'h00000000_BEEF0000);
    rd("fwd_half_rd", BASE + 64'h8, 2'd3, 64'hAAAAAAAA_BEEFAAAA);
    rd("ws0_rd0", BASE, 2'd3, 64'h1);
    drain();
    chk("ws0_idle_hready", 64'(hready0), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_ram_slave.md
Name: data_ram_slave

Overview:
- Bus responder: single-port 64-bit data RAM on the shared memory bus.
- Answers transfers that the memory controller forwards from the inst-fetch and data-access initiators.
- Simplified AHB-Lite style: 1-bit HTRANS, pipelined address/data phases, programmable wait states, HREADY/HRESP back-pressure.
- Complements the read-only internal ROM with a read/write region.

Parameters:
- DEPTH_WORDS, 512, number of 64-bit words; power of two.
- WAIT_STATES, 1, HREADY-low cycles inserted per data phase (0..7).
- BASE_ADDR, 64'h0000_0000_8000_0000, byte address of word 0; aligned to DEPTH_WORDS*8.

Ports:
- CLK  input  1  clock, rising-edge.
- RESET  input  1  asynchronous, active-low reset.
- HSEL  input  1  slave select from the memory controller.
- HTRANS  input  1  1 = active transfer, 0 = idle.
- HADDR  input  64  byte address (address phase).
- HWRITE  input  1  1 = write, 0 = read (address phase).
- HSIZE  input  2  transfer size: 00 byte, 01 half, 10 word, 11 dword (address phase).
- HWDATA  input  64  write data, lane-aligned little-endian (data phase).
- HRDATA  output  64  read data, full 64-bit word containing the address.
- HREADY  output  1  1 = data phase completes this cycle / slave can take a new address.
- HRESP  output  1  1 = error response.

Behaviour:
- Clock and reset: one clock CLK; reset RESET is asynchronous, active-low.
- Reset values: HREADY=1, HRESP=0, HRDATA=0, state IDLE, wait counter 0. The RAM array is not reset.
- Reset asserted mid-transfer aborts it. A pending write is not committed; RAM contents are otherwise retained.
- Accept condition: HSEL & HTRANS & HREADY at a rising edge latches HADDR, HWRITE and HSIZE.
- Word index = (HADDR - BASE_ADDR) >> 3, using log2(DEPTH_WORDS) bits.
- States:
  - IDLE: HREADY=1.
  - WAIT: HREADY=0; counter runs 0..WAIT_STATES-1.
  - DATA: HREADY=1, one cycle.
  - ERR1: HREADY=0, HRESP=1.
  - ERR2: HREADY=1, HRESP=1.
- Transitions:
  - Accept: to WAIT if WAIT_STATES>0, else to DATA.
  - WAIT: to DATA after WAIT_STATES cycles.
  - DATA with a new accept: re-enter WAIT/DATA (back-to-back, no bubble).
  - DATA without an accept: to IDLE.
- Latency: the read data phase completes WAIT_STATES+1 cycles after the accept edge. HRDATA is valid while in DATA and holds its value until the next read's DATA.
- Write: HWDATA is sampled on the edge ending DATA. Only the byte lanes selected by HADDR[2:0] and HSIZE are written (1/2/4/8 bytes). Reads ignore HSIZE lanes.
- Read-after-write hazard (WAIT_STATES=0): a read accepted on the same edge that a write to the same word commits returns the merged post-write word (forwarding).
- HWRITE=1 with HSEL=0, or HTRANS=0: no effect.

Optional Feature:
- Macro: DATA_RAM_ERR_EN.
- Defined:
  - A misaligned access (HADDR[2:0] not a multiple of the size) gets a two-cycle error: ERR1 then ERR2. No write occurs and HRDATA is unchanged.
  - An address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*8) gets the same error.
  - An accept during ERR2 is honoured as normal.
- Undefined:
  - HRESP is tied to 0.
  - The index wraps modulo DEPTH_WORDS.
  - Misaligned addresses are force-aligned by clearing the low log2(size) bits.

Test Plan:
- Reset with RESET=0 during WAIT of a write to 0x80000010 (data 0x1122334455667788) → HREADY=1, HRESP=0, HRDATA=0; a subsequent read of 0x80000010 does not return 0x1122334455667788.
- WAIT_STATES=1: dword write 0x80000008 = 0xDEADBEEFCAFEF00D, then read → HREADY low exactly 1 cycle per transfer; read returns 0xDEADBEEFCAFEF00D 2 cycles after accept.
- Byte write HSIZE=00 at 0x80000009, HWDATA[15:8]=0xAA over the previous word → read returns 0xDEADBEEFCAFEAA0D.
- WAIT_STATES=0: back-to-back write 0x80000000 = 0x1 then read 0x80000000 → HREADY stays 1; read data = 0x1 (forwarding).
- DATA_RAM_ERR_EN defined, word read at 0x80000002 → HREADY=0/HRESP=1 then HREADY=1/HRESP=1, then idle with HRESP=0.
- DATA_RAM_ERR_EN undefined, same read → HRESP stays 0; returns the word at 0x80000000.
